// File: rtl/as2650_wb_pkg.sv
// Shared constants for the AS2650 Wishbone timer/debug register bank:
// register word indices, ID value, TCTRL bit positions and handshake states.
package as2650_wb_pkg;

  localparam logic [31:0] ID_VALUE = 32'h2650_0002;

  localparam logic [5:0] IDX_ID     = 6'd0;
  localparam logic [5:0] IDX_CTRL   = 6'd1;
  localparam logic [5:0] IDX_STATUS = 6'd2;
  localparam logic [5:0] IDX_PEND   = 6'd3;

  // Each timer owns a block of four words starting at word 4.
  localparam int TMR_BASE   = 4;
  localparam int TMR_STRIDE = 4;

  localparam logic [1:0] TMR_COUNT = 2'd0;
  localparam logic [1:0] TMR_CMP   = 2'd1;
  localparam logic [1:0] TMR_TCTRL = 2'd2;

  localparam int TC_EN      = 0;
  localparam int TC_AUTOCLR = 1;
  localparam int TC_IEN     = 2;

  typedef enum logic [1:0] {
    HS_IDLE = 2'd0,
    HS_WAIT = 2'd1,
    HS_ACK  = 2'd2
  } hs_state_e;

  function automatic logic [5:0] tmr_idx(input int n, input logic [1:0] off);
    return 6'(TMR_BASE + TMR_STRIDE * n) | {4'b0000, off};
  endfunction

endpackage

// File: rtl/wb_timer_chan.sv
// One compare timer channel: COUNT/CMP/TCTRL registers, match detection
// and a sticky pending flag with write-1-to-clear.
module wb_timer_chan
  import as2650_wb_pkg::*;
#(
  parameter int TIMER_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_count,
  input  logic               wr_cmp,
  input  logic               wr_tctrl,
  input  logic               w1c,
  input  logic [TIMER_W-1:0] wdata,
  input  logic [2:0]         tctrl_wdata,
  output logic [TIMER_W-1:0] count,
  output logic [TIMER_W-1:0] cmp,
  output logic [2:0]         tctrl,
  output logic               pend,
  output logic               irq
);

  logic match;

  assign match = tctrl[TC_EN] && (count == cmp);
  assign irq   = pend & tctrl[TC_IEN];

  // A bus write to COUNT takes priority over both increment and auto-clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (wr_count) begin
      count <= wdata;
    end else if (tctrl[TC_EN]) begin
      count <= (match && tctrl[TC_AUTOCLR]) ? '0 : count + TIMER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp   <= '0;
      tctrl <= '0;
    end else begin
      if (wr_cmp)   cmp   <= wdata;
      if (wr_tctrl) tctrl <= tctrl_wdata;
    end
  end

  // A match in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0;
    end else if (match) begin
      pend <= 1'b1;
    end else if (w1c) begin
      pend <= 1'b0;
    end
  end

endmodule

// File: rtl/wb_timer_debug_bank.sv
// Wishbone slave with programmable ack latency exposing an ID word, a control
// byte, a debug status snapshot and a bank of compare timers with interrupts.
module wb_timer_debug_bank
  import as2650_wb_pkg::*;
#(
  parameter int NUM_TIMERS = 2,
  parameter int TIMER_W    = 32,
  parameter int DBG_W      = 16,
  parameter int ACK_DELAY  = 2
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  input  logic                  wbs_we_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  output logic [31:0]           wbs_dat_o,
  output logic                  wbs_ack_o,
  input  logic [DBG_W-1:0]      dbg_status_i,
  output logic [7:0]            ctrl_o,
  output logic [NUM_TIMERS-1:0] irq_o
);

  // Handshake: an access is accepted only in IDLE when cyc&stb are high;
  // writes commit and read data is captured on that edge, ack follows
  // exactly ACK_DELAY cycles later for one cycle; dropping cyc while
  // waiting aborts without an ack.
  hs_state_e state_q, state_d;
  logic [2:0] dly_q, dly_d;
  logic       accept, wr_en, pend_wr;
  logic [5:0] idx;
  logic [7:0] ctrl_q;
  logic [31:0] rdata;
  logic        unused_adr;

  logic [NUM_TIMERS-1:0][TIMER_W-1:0] cnt_v, cmp_v;
  logic [NUM_TIMERS-1:0][2:0]         tctrl_v;
  logic [NUM_TIMERS-1:0]              pend_v;

  assign idx        = wbs_adr_i[7:2];
  assign unused_adr = ^{wbs_adr_i[31:8], wbs_adr_i[1:0]};
  assign accept     = (state_q == HS_IDLE) && wbs_cyc_i && wbs_stb_i;
  assign wr_en      = accept && wbs_we_i;
  assign pend_wr    = wr_en && (idx == IDX_PEND);
  assign wbs_ack_o  = (state_q == HS_ACK);
  assign ctrl_o     = ctrl_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= HS_IDLE;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    case (state_q)
      HS_IDLE: begin
        if (accept) begin
          if (ACK_DELAY == 1) begin
            state_d = HS_ACK;
          end else begin
            state_d = HS_WAIT;
            dly_d   = 3'(ACK_DELAY - 1);
          end
        end
      end
      HS_WAIT: begin
        if (!wbs_cyc_i) begin
          state_d = HS_IDLE;
        end else if (dly_q == 3'd1) begin
          state_d = HS_ACK;
          dly_d   = '0;
        end else begin
          dly_d = dly_q - 3'd1;
        end
      end
      HS_ACK:  state_d = HS_IDLE;
      default: state_d = HS_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      ctrl_q <= '0;
    end else if (wr_en && (idx == IDX_CTRL)) begin
      ctrl_q <= wbs_dat_i[7:0];
    end
  end

  // The read buffer doubles as the debug snapshot: STATUS captures
  // dbg_status_i as it is in the acceptance cycle.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wbs_dat_o <= '0;
    end else if (accept && !wbs_we_i) begin
      wbs_dat_o <= rdata;
    end
  end

  for (genvar n = 0; n < NUM_TIMERS; n++) begin : g_chan
    wb_timer_chan #(
      .TIMER_W(TIMER_W)
    ) u_chan (
      .clk        (wb_clk_i),
      .rst_n      (wb_rst_n),
      .wr_count   (wr_en && (idx == tmr_idx(n, TMR_COUNT))),
      .wr_cmp     (wr_en && (idx == tmr_idx(n, TMR_CMP))),
      .wr_tctrl   (wr_en && (idx == tmr_idx(n, TMR_TCTRL))),
      .w1c        (pend_wr && wbs_dat_i[n]),
      .wdata      (wbs_dat_i[TIMER_W-1:0]),
      .tctrl_wdata(wbs_dat_i[2:0]),
      .count      (cnt_v[n]),
      .cmp        (cmp_v[n]),
      .tctrl      (tctrl_v[n]),
      .pend       (pend_v[n]),
      .irq        (irq_o[n])
    );
  end

  always_comb begin
    rdata = 32'hFFFF_FFFF;
    case (idx)
      IDX_ID:     rdata = ID_VALUE;
      IDX_CTRL:   rdata = {24'h0, ctrl_q};
      IDX_STATUS: rdata = 32'(dbg_status_i);
      IDX_PEND:   rdata = 32'(pend_v);
      default: begin
        for (int n = 0; n < NUM_TIMERS; n++) begin
          if (idx == tmr_idx(n, TMR_COUNT)) rdata = 32'(cnt_v[n]);
          if (idx == tmr_idx(n, TMR_CMP))   rdata = 32'(cmp_v[n]);
          if (idx == tmr_idx(n, TMR_TCTRL)) rdata = 32'(tctrl_v[n]);
        end
      end
    endcase
  end

endmodule

// File: tb/tb_wb_timer_debug_bank.sv
// Self-checking bench for wb_timer_debug_bank: random register traffic against
// a register model, plus timer, W1C, abort and async-reset scenarios.
module tb_wb_timer_debug_bank;

  localparam int NUM_TIMERS = 2;
  localparam int TIMER_W    = 32;
  localparam int DBG_W      = 16;
  localparam int ACK_DELAY  = 2;

  logic                  wb_clk_i = 1'b0;
  logic                  wb_rst_n = 1'b0;
  logic [31:0]           wbs_adr_i = '0;
  logic [31:0]           wbs_dat_i = '0;
  logic                  wbs_we_i = 1'b0;
  logic                  wbs_cyc_i = 1'b0;
  logic                  wbs_stb_i = 1'b0;
  logic [31:0]           wbs_dat_o;
  logic                  wbs_ack_o;
  logic [DBG_W-1:0]      dbg_status_i = '0;
  logic [7:0]            ctrl_o;
  logic [NUM_TIMERS-1:0] irq_o;

  wb_timer_debug_bank #(
    .NUM_TIMERS(NUM_TIMERS),
    .TIMER_W   (TIMER_W),
    .DBG_W     (DBG_W),
    .ACK_DELAY (ACK_DELAY)
  ) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_n    (wb_rst_n),
    .wbs_adr_i   (wbs_adr_i),
    .wbs_dat_i   (wbs_dat_i),
    .wbs_we_i    (wbs_we_i),
    .wbs_cyc_i   (wbs_cyc_i),
    .wbs_stb_i   (wbs_stb_i),
    .wbs_dat_o   (wbs_dat_o),
    .wbs_ack_o   (wbs_ack_o),
    .dbg_status_i(dbg_status_i),
    .ctrl_o      (ctrl_o),
    .irq_o       (irq_o)
  );

  // ---------------- clock / reset / edge counter ----------------
  always #5 wb_clk_i = ~wb_clk_i;

  int unsigned tick = 0;
  always @(posedge wb_clk_i) tick <= tick + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model[int];
  logic [DBG_W-1:0] next_dbg = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Expected read value from the register map for the current register model.
  function automatic logic [31:0] exp_rd(input int idx);
    if (idx == 0) return 32'h2650_0002;
    if (idx == 2) return 32'(next_dbg);
    if (idx == 3) return 32'h0;
    if (idx == 7 || idx == 11 || idx >= 12) return 32'hFFFF_FFFF;
    if (model.exists(idx)) return model[idx];
    return 32'h0;
  endfunction

  function automatic logic [31:0] a_of(input int idx);
    logic [5:0] w;
    w = idx[5:0];
    return {8'($urandom), 16'($urandom), w, 2'($urandom)};
  endfunction

  // ---------------- driver ----------------
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input bit hold, output logic [31:0] rdata,
                         output int unsigned acc_edge, output logic [7:0] ctrl_next);
    int lat;
    bit got_ack;
    @(negedge wb_clk_i);
    wbs_cyc_i    = 1'b1;
    wbs_stb_i    = 1'b1;
    wbs_we_i     = we;
    wbs_adr_i    = adr;
    wbs_dat_i    = dat;
    dbg_status_i = next_dbg;
    acc_edge     = tick + 1;
    lat          = 0;
    got_ack      = 1'b0;
    rdata        = '0;
    ctrl_next    = '0;
    while (!got_ack && lat < 16) begin
      @(negedge wb_clk_i);
      lat++;
      if (lat == 1) begin
        ctrl_next    = ctrl_o;
        dbg_status_i = ~next_dbg;
      end
      if (wbs_ack_o) begin
        got_ack = 1'b1;
        rdata   = wbs_dat_o;
      end
    end
    chk("ack_seen", 32'(got_ack), 32'd1);
    if (got_ack) chk("ack_latency", 32'(lat), 32'(ACK_DELAY));
    if (hold && got_ack) begin
      @(negedge wb_clk_i);
      chk("ack_single_pulse", 32'(wbs_ack_o), 32'd0);
    end
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
  endtask

  task automatic wr(input int idx, input logic [31:0] dat, output int unsigned e);
    logic [31:0] r;
    logic [7:0]  c;
    wb_xfer(1'b1, a_of(idx), dat, 1'b0, r, e, c);
  endtask

  task automatic rd(input int idx, output logic [31:0] r, output int unsigned e);
    logic [7:0] c;
    wb_xfer(1'b0, a_of(idx), $urandom, 1'b0, r, e, c);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] r;
    logic [31:0] d;
    logic [7:0]  cn;
    int unsigned ea, eb, ed, ew, er, m;
    int          idx;
    bit          we;
    bit          ack_seen;
    logic [31:0] c1;
    int unsigned f0;

    repeat (3) @(negedge wb_clk_i);
    wb_rst_n = 1'b1;
    @(negedge wb_clk_i);
    chk("rst_ack", 32'(wbs_ack_o), 32'd0);
    chk("rst_dat", wbs_dat_o, 32'd0);
    chk("rst_ctrl", 32'(ctrl_o), 32'd0);
    chk("rst_irq", 32'(irq_o), 32'd0);

    rd(0, r, ea);
    chk("id", r, 32'h2650_0002);
    wb_xfer(1'b0, 32'h0000_0040, 32'h0, 1'b0, r, ea, cn);
    chk("unmapped_40", r, 32'hFFFF_FFFF);

    // CTRL write with strobe held through the ack.
    wb_xfer(1'b1, a_of(1), 32'hFFFF_FFA5, 1'b1, r, ea, cn);
    chk("ctrl_next_cycle", 32'(cn), 32'hA5);
    model[1] = 32'hA5;
    rd(1, r, ea);
    chk("ctrl_readback", r, 32'hA5);

    // Random register traffic with timers kept stopped.
    for (int i = 0; i < 40; i++) begin
      idx      = $urandom_range(0, 63);
      we       = 1'($urandom_range(0, 1));
      d        = $urandom;
      next_dbg = DBG_W'($urandom);
      if (idx == 6 || idx == 10) d[0] = 1'b0;
      if (we) begin
        wr(idx, d, ea);
        case (idx)
          1:          model[1]   = {24'h0, d[7:0]};
          4, 5, 8, 9: model[idx] = d;
          6, 10:      model[idx] = {29'h0, d[2:0]};
          default: ;
        endcase
      end else begin
        exp_q.push_back(exp_rd(idx));
        rd(idx, r, ea);
        chk($sformatf("rand_rd_w%0d", idx), r, exp_q.pop_front());
      end
    end
    for (int k = 0; k < 7; k++) begin
      idx = (k == 0) ? 1 : (k < 4 ? k + 3 : k + 4);
      next_dbg = DBG_W'($urandom);
      exp_q.push_back(exp_rd(idx));
      rd(idx, r, ea);
      chk($sformatf("sweep_rd_w%0d", idx), r, exp_q.pop_front());
    end
    next_dbg = DBG_W'($urandom);
    rd(2, r, ea);
    chk("status_snapshot", r, 32'(next_dbg));

    // Timer 0: CMP=5, AUTOCLR, IEN. Count runs 0..5 with period 6,
    // first match seen while count==5, pending visible one edge later.
    wr(10, 32'h0, ea);
    wr(5, 32'd5, ea);
    wr(4, 32'd0, ea);
    wr(6, 32'h7, eb);
    for (int k = 0; k < 10; k++) begin
      chk("irq0_rise", 32'(irq_o), 32'(tick >= eb + 6));
      @(negedge wb_clk_i);
    end
    rd(4, r, er);
    chk("cnt0_autoclr", r, 32'((er - 1 - eb) % 6));
    rd(3, r, ea);
    chk("pend_after_match", r, 32'h1);
    wr(6, 32'h6, ed);
    f0 = (ed - eb) % 6;
    rd(4, r, ea);
    chk("cnt0_frozen", r, 32'(f0));
    wr(3, 32'hFFFF_FFFE, ea);
    chk("w1c_zero_no_effect", 32'(irq_o), 32'h1);
    wr(3, 32'h1, ew);
    chk("irq0_fall", 32'(irq_o), 32'h0);

    // Timer 1: free-running across the wrap, CMP=3; W1C lands on the match edge.
    c1 = 32'hFFFF_FFFE;
    wr(9, 32'd3, ea);
    wr(8, c1, ea);
    wr(10, 32'h5, eb);
    m = eb + 6;
    for (int k = 0; k < 8 && tick < eb + 4; k++) @(negedge wb_clk_i);
    wr(3, 32'h2, ew);
    chk("match_beats_w1c", 32'(irq_o), {30'h0, (ew <= m), 1'b0});
    rd(8, r, er);
    chk("cnt1_wrap", r, c1 + 32'(er - 1 - eb));
    rd(3, r, ea);
    chk("pend_bit1", r, {30'h0, (ew <= m), 1'b0});
    wr(3, 32'h2, ea);
    chk("irq1_fall", 32'(irq_o), 32'h0);

    // Abort: cyc drops one cycle after a write to CMP_1 is accepted.
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = 1'b1;
    wbs_adr_i = a_of(9);
    wbs_dat_i = 32'h0000_1234;
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    ack_seen  = 1'b0;
    repeat (6) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o) ack_seen = 1'b1;
    end
    chk("abort_no_ack", 32'(ack_seen), 32'd0);
    rd(9, r, ea);
    chk("abort_write_kept", r, 32'h0000_1234);

    // Asynchronous reset while a read is waiting for its ack.
    wb_xfer(1'b1, a_of(1), 32'h5A, 1'b0, r, ea, cn);
    chk("ctrl_pre_rst", 32'(cn), 32'h5A);
    wr(6, 32'h7, ea);
    repeat (10) @(negedge wb_clk_i);
    chk("irq0_pre_rst", 32'(irq_o), 32'h1);
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = 1'b0;
    wbs_adr_i = a_of(0);
    @(negedge wb_clk_i);
    #1 wb_rst_n = 1'b0;
    #1;
    chk("async_rst_ack", 32'(wbs_ack_o), 32'd0);
    chk("async_rst_irq", 32'(irq_o), 32'd0);
    chk("async_rst_ctrl", 32'(ctrl_o), 32'd0);
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    ack_seen  = 1'b0;
    repeat (3) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o) ack_seen = 1'b1;
    end
    chk("rst_no_ack", 32'(ack_seen), 32'd0);
    wb_rst_n = 1'b1;
    rd(0, r, ea);
    chk("id_after_rst", r, 32'h2650_0002);
    rd(1, r, ea);
    chk("ctrl_after_rst", r, 32'h0);
    rd(9, r, ea);
    chk("cmp1_after_rst", r, 32'h0);
    rd(3, r, ea);
    chk("pend_after_rst", r, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
